// File: rtl/mp3_ui_pkg.sv
// Shared layout constants, colours and the RGB565 expansion helper for the MP3 UI screen.
package mp3_ui_pkg;

  localparam int COVER_SIZE    = 128;
  localparam int COVER_TOP_OFS = 144;  // cover spans cy-144 .. cy-17
  localparam int SQ_SIZE       = 16;
  localparam int SQ_PITCH      = 24;
  localparam int SEL_X_OFS     = 48;
  localparam int SEL_Y_OFS     = 16;
  localparam int SEG_SIZE      = 16;
  localparam int SEG_PITCH     = 20;
  localparam int VOL_X_OFS     = 160;
  localparam int VOL_Y_OFS     = 80;
  localparam int NUM_SONGS     = 4;
  localparam int VOL_MAX       = 15;

  localparam logic [3:0] VOL_RESET = 4'd8;

  localparam logic [23:0] COL_BG      = 24'h101020;
  localparam logic [23:0] COL_SEL_ON  = 24'hFFFFFF;
  localparam logic [23:0] COL_SEL_OFF = 24'h404040;
  localparam logic [23:0] COL_VOL_ON  = 24'h00C000;
  localparam logic [23:0] COL_VOL_OFF = 24'h303030;

  // Replicate the top bits so full-scale 565 maps to full-scale 888.
  function automatic logic [23:0] rgb565_expand(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

endpackage

// File: rtl/mp3_ui_display_button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, one-cycle pulse on a
// debounced rising edge.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]      sync_q;
  logic            stable_q;
  logic [CntW-1:0] cnt_q;
  logic            pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b00;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      pulse_q <= 1'b0;
      // Any return to the stable level restarts the count.
      if (sync_q[1] != stable_q) begin
        if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
          stable_q <= sync_q[1];
          cnt_q    <= '0;
          pulse_q  <= sync_q[1];
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/mp3_ui_display.sv
// MP3 player pixel generator: button-driven song/volume state, vsync-latched display copies,
// and a 3-stage render pipeline (cover from BRAM, song selector, volume bar).
module mp3_ui_display
  import mp3_ui_pkg::*;
#(
  parameter int          H_RES           = 640,
  parameter int          V_RES           = 480,
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] i_x,
  input  logic signed [15:0] i_y,
  input  logic               i_next,
  input  logic               i_pre,
  input  logic               i_vol_plus,
  input  logic               i_vol_dec,
  input  logic               i_vs,
  input  logic [15:0]        doutb,
  output logic [7:0]         o_red,
  output logic [7:0]         o_green,
  output logic [7:0]         o_blue,
  output logic [14:0]        addrb
);

  localparam int CX = H_RES / 2;
  localparam int CY = V_RES / 2;

  localparam logic signed [15:0] COV_X0 = 16'(CX - COVER_SIZE / 2);
  localparam logic signed [15:0] COV_X1 = 16'(CX + COVER_SIZE / 2 - 1);
  localparam logic signed [15:0] COV_Y0 = 16'(CY - COVER_TOP_OFS);
  localparam logic signed [15:0] COV_Y1 = 16'(CY - COVER_TOP_OFS + COVER_SIZE - 1);
  localparam logic signed [15:0] SEL_Y0 = 16'(CY + SEL_Y_OFS);
  localparam logic signed [15:0] SEL_Y1 = 16'(CY + SEL_Y_OFS + SQ_SIZE - 1);
  localparam logic signed [15:0] VOL_Y0 = 16'(CY + VOL_Y_OFS);
  localparam logic signed [15:0] VOL_Y1 = 16'(CY + VOL_Y_OFS + SEG_SIZE - 1);

  function automatic logic signed [15:0] sq_x0(input int k);
    return 16'(CX - SEL_X_OFS + SQ_PITCH * k);
  endfunction

  function automatic logic signed [15:0] sq_x1(input int k);
    return 16'(CX - SEL_X_OFS + SQ_PITCH * k + SQ_SIZE - 1);
  endfunction

  function automatic logic signed [15:0] seg_x0(input int i);
    return 16'(CX - VOL_X_OFS + SEG_PITCH * i);
  endfunction

  function automatic logic signed [15:0] seg_x1(input int i);
    return 16'(CX - VOL_X_OFS + SEG_PITCH * i + SEG_SIZE - 1);
  endfunction

  // Buttons
  logic next_p, pre_p, plus_p, dec_p;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .rst_n(rst_n), .btn_i(i_next), .pulse_o(next_p)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pre (
    .clk(clk), .rst_n(rst_n), .btn_i(i_pre), .pulse_o(pre_p)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_plus (
    .clk(clk), .rst_n(rst_n), .btn_i(i_vol_plus), .pulse_o(plus_p)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
    .clk(clk), .rst_n(rst_n), .btn_i(i_vol_dec), .pulse_o(dec_p)
  );

  // UI state and frame latch
  logic [1:0] song_q, disp_song_q;
  logic [3:0] vol_q, disp_vol_q;
  logic [2:0] vs_q;  // [1:0] synchroniser, [2] previous synchronised level

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      song_q      <= 2'd0;
      vol_q       <= VOL_RESET;
      disp_song_q <= 2'd0;
      disp_vol_q  <= VOL_RESET;
      vs_q        <= 3'b111;
    end else begin
      vs_q <= {vs_q[1:0], i_vs};
      if (next_p && !pre_p) begin
        song_q <= song_q + 2'd1;
      end else if (pre_p && !next_p) begin
        song_q <= song_q - 2'd1;
      end
      if (plus_p && !dec_p && vol_q != 4'(VOL_MAX)) begin
        vol_q <= vol_q + 4'd1;
      end else if (dec_p && !plus_p && vol_q != 4'd0) begin
        vol_q <= vol_q - 4'd1;
      end
      if (vs_q[2] && !vs_q[1]) begin
        disp_song_q <= song_q;
        disp_vol_q  <= vol_q;
      end
    end
  end

  // Stage 1 decision
  logic        cover_hit, sel_hit, sel_on, vol_hit, vol_on;
  logic [6:0]  cov_ox, cov_oy;
  logic [23:0] colour_d;

  always_comb begin
    cover_hit = (i_x >= COV_X0) && (i_x <= COV_X1) && (i_y >= COV_Y0) && (i_y <= COV_Y1);
    cov_ox    = 7'(i_x - COV_X0);
    cov_oy    = 7'(i_y - COV_Y0);
    sel_hit   = 1'b0;
    sel_on    = 1'b0;
    vol_hit   = 1'b0;
    vol_on    = 1'b0;
    for (int k = 0; k < NUM_SONGS; k++) begin
      if (i_y >= SEL_Y0 && i_y <= SEL_Y1 && i_x >= sq_x0(k) && i_x <= sq_x1(k)) begin
        sel_hit = 1'b1;
        sel_on  = (2'(k) == disp_song_q);
      end
    end
    for (int i = 0; i <= VOL_MAX; i++) begin
      if (i_y >= VOL_Y0 && i_y <= VOL_Y1 && i_x >= seg_x0(i) && i_x <= seg_x1(i)) begin
        vol_hit = 1'b1;
        vol_on  = (4'(i) < disp_vol_q);
      end
    end
    colour_d = COL_BG;
    if (!cover_hit) begin
      if (sel_hit) begin
        colour_d = sel_on ? COL_SEL_ON : COL_SEL_OFF;
      end else if (vol_hit) begin
        colour_d = vol_on ? COL_VOL_ON : COL_VOL_OFF;
      end
    end
  end

  // Pipeline: stage 2 waits for the BRAM word, stage 3 picks the final colour.
  logic        cover_q1, cover_q2;
  logic [23:0] colour_q1, colour_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addrb     <= 15'd0;
      cover_q1  <= 1'b0;
      cover_q2  <= 1'b0;
      colour_q1 <= 24'd0;
      colour_q2 <= 24'd0;
      o_red     <= 8'd0;
      o_green   <= 8'd0;
      o_blue    <= 8'd0;
    end else begin
      if (cover_hit) begin
        addrb <= {disp_song_q[0], cov_oy, cov_ox};
      end
      cover_q1  <= cover_hit;
      colour_q1 <= colour_d;
      cover_q2  <= cover_q1;
      colour_q2 <= colour_q1;
      {o_red, o_green, o_blue} <= cover_q2 ? rgb565_expand(doutb) : colour_q2;
    end
  end

endmodule

// File: tb/tb_mp3_ui_display.sv
// Scoreboard bench for mp3_ui_display: a behavioural UI model predicts addrb and colour for
// each driven pixel; a negedge monitor pops and compares as the pipeline delivers them.
module tb_mp3_ui_display;

  localparam int DEB = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] i_x, i_y;
  logic               i_next, i_pre, i_vol_plus, i_vol_dec, i_vs;
  logic [15:0]        doutb = 16'd0;
  logic [7:0]         o_red, o_green, o_blue;
  logic [14:0]        addrb;

  always #5 clk = ~clk;

  mp3_ui_display #(.H_RES(640), .V_RES(480), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .i_x(i_x), .i_y(i_y), .i_next(i_next), .i_pre(i_pre),
    .i_vol_plus(i_vol_plus), .i_vol_dec(i_vol_dec), .i_vs(i_vs), .doutb(doutb),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue), .addrb(addrb)
  );

  function automatic logic [15:0] rom(input logic [14:0] a);
    if (a == 15'd0) return 16'hF800;
    return {a, 1'b0} ^ 16'h5A3C;
  endfunction

  always @(posedge clk) doutb <= rom(addrb);

  function automatic logic [23:0] expand(input logic [15:0] d);
    logic [4:0] r, b;
    logic [5:0] g;
    r = d[15:11];
    g = d[10:5];
    b = d[4:0];
    return {r, r[4:2], g, g[5:4], b, b[4:2]};
  endfunction

  // Reference UI model
  int          m_song = 0, m_vol = 8, m_dsong = 0, m_dvol = 8;
  logic [14:0] m_addr = 15'd0;

  typedef struct {
    string       tag;
    logic [23:0] val;
  } exp_t;

  exp_t col_q[$];
  exp_t addr_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  logic       drv_valid = 1'b0;
  logic [2:0] vpipe = 3'b000;

  always @(posedge clk) vpipe <= {vpipe[1:0], drv_valid};

  always @(negedge clk) begin
    if (vpipe[0]) begin
      n_checks++;
      if (addr_q.size() == 0) begin
        n_fail++;
        $display("FAIL addr_underflow: addrb=%h with no expectation queued", addrb);
      end else begin
        mon_e = addr_q.pop_front();
        if (addrb !== mon_e.val[14:0]) begin
          n_fail++;
          $display("FAIL %s addrb: got %h, expected %h", mon_e.tag, addrb, mon_e.val[14:0]);
        end
      end
    end
    if (vpipe[2]) begin
      n_checks++;
      if (col_q.size() == 0) begin
        n_fail++;
        $display("FAIL colour_underflow: rgb=%h with no expectation queued",
                 {o_red, o_green, o_blue});
      end else begin
        mon_e = col_q.pop_front();
        if ({o_red, o_green, o_blue} !== mon_e.val) begin
          n_fail++;
          $display("FAIL %s colour: got %h, expected %h", mon_e.tag,
                   {o_red, o_green, o_blue}, mon_e.val);
        end
      end
    end
  end

  task automatic model_pixel(input int x, input int y, output logic [23:0] col);
    bit hit;
    hit = 1'b0;
    col = 24'h101020;
    if (x >= 256 && x <= 383 && y >= 96 && y <= 223) begin
      m_addr = {m_dsong[0], 7'(y - 96), 7'(x - 256)};
      col = expand(rom(m_addr));
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (y >= 256 && y <= 271 && x >= 272 + 24 * k && x <= 287 + 24 * k) begin
          hit = 1'b1;
          col = (k == m_dsong) ? 24'hFFFFFF : 24'h404040;
        end
      end
      if (!hit) begin
        for (int i = 0; i < 16; i++) begin
          if (y >= 320 && y <= 335 && x >= 160 + 20 * i && x <= 175 + 20 * i) begin
            col = (i < m_dvol) ? 24'h00C000 : 24'h303030;
          end
        end
      end
    end
  endtask

  // Drives one coordinate for one cycle (caller sits just after a negedge).
  task automatic pixel(input int x, input int y, input string tag, input bit park);
    logic [23:0] c;
    model_pixel(x, y, c);
    i_x = 16'(x);
    i_y = 16'(y);
    drv_valid = 1'b1;
    col_q.push_back('{tag, c});
    addr_q.push_back('{tag, {9'd0, m_addr}});
    @(negedge clk);
    drv_valid = 1'b0;
    if (park) begin
      i_x = -16'sd1;
      i_y = -16'sd1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((col_q.size() != 0 || addr_q.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (col_q.size() != 0 || addr_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d colour and %0d addr expectations left",
               col_q.size(), addr_q.size());
      col_q.delete();
      addr_q.delete();
    end
  endtask

  task automatic press(input bit nx, input bit pv, input bit vp, input bit vd, input int hold);
    i_next = nx;
    i_pre = pv;
    i_vol_plus = vp;
    i_vol_dec = vd;
    repeat (hold) @(negedge clk);
    {i_next, i_pre, i_vol_plus, i_vol_dec} = 4'b0000;
    repeat (10) @(negedge clk);
    if (hold > DEB + 1) begin
      if (nx && !pv) m_song = (m_song + 1) % 4;
      else if (pv && !nx) m_song = (m_song + 3) % 4;
      if (vp && !vd && m_vol < 15) m_vol++;
      else if (vd && !vp && m_vol > 0) m_vol--;
    end
  endtask

  task automatic vsync();
    i_vs = 1'b0;
    repeat (4) @(negedge clk);
    i_vs = 1'b1;
    repeat (4) @(negedge clk);
    m_dsong = m_song;
    m_dvol = m_vol;
  endtask

  task automatic check_squares(input string tag);
    for (int k = 0; k < 4; k++) pixel(280 + 24 * k, 264, $sformatf("%s_sq%0d", tag, k), 1'b1);
    drain();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_vs = 1'b1;
    {i_next, i_pre, i_vol_plus, i_vol_dec} = 4'b0000;
    i_x = 16'sd320;
    i_y = 16'sd400;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o_red, o_green, o_blue} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_rgb: got %h, expected 000000", {o_red, o_green, o_blue});
    end
    n_checks++;
    if (addrb !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_addrb: got %h, expected 0000", addrb);
    end
    rst_n = 1'b1;
    @(negedge clk);
    pixel(320, 400, "reset_bg", 1'b1);
    check_squares("reset");
    pixel(308, 328, "reset_seg7", 1'b1);
    pixel(328, 328, "reset_seg8", 1'b1);
    pixel(-5, 100, "negative_x", 1'b1);
    drain();
  endtask

  task automatic test_cover();
    pixel(256, 96, "cover_first", 1'b1);
    pixel(383, 223, "cover_last", 1'b1);
    pixel(300, 150, "cover_mid", 1'b1);
    pixel(400, 150, "cover_right_out", 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int x = 252; x < 262; x++) pixel(x, 100, $sformatf("b2b_x%0d", x), 1'b0);
    pixel(383, 223, "b2b_corner", 1'b0);
    pixel(384, 223, "b2b_edge_out", 1'b0);
    pixel(290, 264, "b2b_sel", 1'b1);
    drain();
  endtask

  task automatic test_song_select();
    repeat (5) press(1'b1, 1'b0, 1'b0, 1'b0, 8);
    vsync();
    check_squares("song1");
    pixel(344, 256, "sel_344_256", 1'b1);
    pixel(256, 96, "cover_song1", 1'b1);
    press(1'b0, 1'b1, 1'b0, 1'b0, 8);
    press(1'b0, 1'b1, 1'b0, 1'b0, 8);
    vsync();
    check_squares("pre_wrap");
  endtask

  task automatic test_volume();
    repeat (10) press(1'b0, 1'b0, 1'b1, 1'b0, 8);
    vsync();
    pixel(440, 328, "vol15_seg14", 1'b1);
    pixel(460, 320, "vol15_seg15", 1'b1);
    pixel(178, 328, "vol_gap", 1'b1);
    drain();
    repeat (20) press(1'b0, 1'b0, 1'b0, 1'b1, 8);
    vsync();
    pixel(160, 320, "vol0_seg0", 1'b1);
    pixel(175, 335, "vol0_seg0_corner", 1'b1);
    drain();
    press(1'b0, 1'b0, 1'b1, 1'b1, 8);
    press(1'b0, 1'b0, 1'b1, 1'b0, 8);
    vsync();
    pixel(168, 328, "vol1_seg0", 1'b1);
    pixel(188, 328, "vol1_seg1", 1'b1);
    drain();
  endtask

  task automatic test_glitch();
    press(1'b1, 1'b0, 1'b0, 1'b0, 2);
    press(1'b1, 1'b1, 1'b0, 1'b0, 8);
    vsync();
    check_squares("glitch");
  endtask

  task automatic test_frame_latch();
    press(1'b1, 1'b0, 1'b0, 1'b0, 8);
    check_squares("no_vsync");
    vsync();
    check_squares("after_vsync");
  endtask

  task automatic test_reset_midframe();
    press(1'b1, 1'b0, 1'b0, 1'b0, 8);
    press(1'b0, 1'b0, 1'b1, 1'b0, 8);
    vsync();
    press(1'b1, 1'b0, 1'b0, 1'b0, 8);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_song = 0;
    m_vol = 8;
    m_dsong = 0;
    m_dvol = 8;
    m_addr = 15'd0;
    check_squares("midreset");
    pixel(308, 328, "midreset_seg7", 1'b1);
    pixel(328, 328, "midreset_seg8", 1'b1);
    pixel(383, 223, "midreset_cover", 1'b1);
    drain();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cover();
    test_back_to_back();
    test_song_select();
    test_volume();
    test_glitch();
    test_frame_latch();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
